duck_ctl: RTL and testbench
===========================

Name: duck_ctl

Overview:
- Duck flight controller; sits directly downstream of the random position generator.
- Consumes its 10-bit horizontal/vertical target coordinates (960x704 playfield).
- Moves the duck sprite toward the target once per video frame.
- Detects mouse hits; drives fall and escape sequences.
- Outputs the sprite position and visibility to the draw stage, and hit/escape event pulses to score logic.

Parameters:
- STEP, 4, pixels moved per axis per frame tick (FLY/ESCAPE).
- FALL_STEP, 8, pixels moved down per frame tick in FALL.
- X_MAX, 960, playfield width.
- Y_MAX, 704, playfield height.
- DUCK_W, 64, sprite width.
- DUCK_H, 64, sprite height.
- ESCAPE_FRAMES, 300, frames in FLY before the duck escapes.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- state_in  in  2  game state; 2'b01 = PLAY, all other codes = not playing
- frame_tick  in  1  one-cycle pulse per video frame
- target_x  in  10  random horizontal target from generator
- target_y  in  10  random vertical target from generator
- click  in  1  one-cycle left-button press pulse
- mouse_x  in  12  cursor x, valid when click=1
- mouse_y  in  12  cursor y, valid when click=1
- duck_x  out  10  sprite top-left x
- duck_y  out  10  sprite top-left y
- duck_visible  out  1  draw enable
- dir_right  out  1  1 = facing right
- hit_pulse  out  1  one-cycle pulse on a hit
- escape_pulse  out  1  one-cycle pulse on an escape

Behaviour:
Constants and clamping:
- XC = X_MAX-DUCK_W = 896; Y_SPAWN = Y_MAX-DUCK_H = 640.
- clamp_x(v) = min(v, XC); clamp_y(v) = min(v, Y_SPAWN).
- Targets are sampled only at the moments below; the generator holds them stable between updates.

Reset:
- state IDLE; duck_x=448, duck_y=640; goal_x=448, goal_y=640.
- duck_visible=0, dir_right=1, hit_pulse=0, escape_pulse=0; frame counter=0.

States: IDLE, SPAWN, FLY, FALL, ESCAPE.
- IDLE: visible=0, position held. Go to SPAWN when state_in==PLAY.
- SPAWN (1 cycle, visible=0):
  - duck_x=clamp_x(target_x), duck_y=Y_SPAWN.
  - goal_x=clamp_x(target_x), goal_y=clamp_y(target_y).
  - Frame counter cleared. Next state FLY.
- FLY (visible=1), on each frame_tick:
  - Each axis moves toward goal by min(STEP, |goal-duck|); never overshoots.
  - dir_right=1 if goal_x>duck_x, 0 if goal_x<duck_x, held if equal.
  - Frame counter increments.
  - If duck==goal on both axes at a tick, reload goal from clamped targets and do not move on that tick.
  - When counter reaches ESCAPE_FRAMES on a tick, go to ESCAPE.
- Hit test (FLY only): click=1 with duck_x<=mouse_x<=duck_x+DUCK_W-1 and duck_y<=mouse_y<=duck_y+DUCK_H-1.
  - Uses 12-bit zero-extended compare.
  - hit_pulse=1 for exactly the next cycle; go to FALL.
- FALL (visible=1), on each frame_tick:
  - duck_y += FALL_STEP, saturating at Y_SPAWN.
  - On the tick where duck_y reaches Y_SPAWN, go to SPAWN.
- ESCAPE (visible=1), on each frame_tick:
  - If duck_y>=STEP, duck_y -= STEP.
  - Otherwise duck_y=0, escape_pulse=1 for one cycle, go to SPAWN.

Timing and priorities:
- Outputs are registered. Movement appears the cycle after frame_tick. hit_pulse appears the cycle after click.
- Simultaneous hit and ESCAPE_FRAMES expiry in the same cycle: hit wins; no escape_pulse.
- click outside FLY is ignored. click on the same cycle as frame_tick is tested against the pre-move position.
- state_in leaving PLAY in any state: IDLE on the next cycle, visible=0, pulses cleared. A pending fall/escape is discarded.
- rst in any state overrides all of the above.

Test Plan:
1. Reset, state_in=01, target=(100,200): SPAWN then FLY with duck=(100,640), visible=1. After 110 ticks, duck=(100,200).
2. target_x=1000, target_y=700 at spawn: duck_x=896; goal clamped to (896,640); no move beyond 896.
3. duck at (300,300), click at (330,363): hit_pulse one cycle, FALL. duck_y steps +8 per tick to 640, then SPAWN; visible drops for 1 cycle.
4. Click at (364,300) with duck at (300,300): no hit (right edge exclusive).
5. No clicks, ESCAPE_FRAMES=300: ESCAPE after 300 ticks. duck_y decrements 4 per tick to 0; escape_pulse once; respawn.
6. Mid-FALL, state_in=00: IDLE next cycle, visible=0, no pulses. Return to 01: fresh SPAWN from current targets.

Source files
------------

// File: rtl/duck_ctl_if.sv
// Signal bundle between the game logic / random generator / mouse and the duck
// controller. The controller is the slave; the bench or game top is the master.
interface duck_ctl_if;
   logic [1:0]  state_in;
   logic        frame_tick;
   logic [9:0]  target_x;
   logic [9:0]  target_y;
   logic        click;
   logic [11:0] mouse_x;
   logic [11:0] mouse_y;
   logic [9:0]  duck_x;
   logic [9:0]  duck_y;
   logic        duck_visible;
   logic        dir_right;
   logic        hit_pulse;
   logic        escape_pulse;

   modport master (
      output state_in, frame_tick, target_x, target_y, click, mouse_x, mouse_y,
      input  duck_x, duck_y, duck_visible, dir_right, hit_pulse, escape_pulse
   );

   modport slave (
      input  state_in, frame_tick, target_x, target_y, click, mouse_x, mouse_y,
      output duck_x, duck_y, duck_visible, dir_right, hit_pulse, escape_pulse
   );
endinterface

// File: rtl/duck_ctl.sv
// Duck flight controller: spawns the sprite at the bottom of the playfield, flies it
// toward random targets once per frame, and handles hits (fall) and timeouts (escape).
module duck_ctl #(
   parameter int STEP          = 4,
   parameter int FALL_STEP     = 8,
   parameter int X_MAX         = 960,
   parameter int Y_MAX         = 704,
   parameter int DUCK_W        = 64,
   parameter int DUCK_H        = 64,
   parameter int ESCAPE_FRAMES = 300
) (
   input  logic       clk,
   input  logic       rst,
   duck_ctl_if.slave  bus
);

   localparam logic [9:0] XC      = 10'(X_MAX - DUCK_W);
   localparam logic [9:0] Y_SPAWN = 10'(Y_MAX - DUCK_H);
   localparam int         CNT_W   = $clog2(ESCAPE_FRAMES + 1);
   localparam logic [1:0] PLAY    = 2'b01;

   typedef enum logic [2:0] {IDLE, SPAWN, FLY, FALL, ESCAPE} state_t;

   state_t             state_q, state_d;
   logic [9:0]         dx_q, dx_d, dy_q, dy_d;
   logic [9:0]         gx_q, gx_d, gy_q, gy_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               vis_q, vis_d, dir_q, dir_d;
   logic               hit_q, hit_d, esc_q, esc_d;
   logic [11:0]        x_lo, x_hi, y_lo, y_hi;
   logic               hit_now, at_goal;

   function automatic logic [9:0] clamp(input logic [9:0] v, input logic [9:0] lim);
      return (v > lim) ? lim : v;
   endfunction

   // Move one axis toward its goal by at most STEP without overshooting.
   function automatic logic [9:0] step_toward(input logic [9:0] cur, input logic [9:0] goal);
      logic [9:0] diff;
      if (goal > cur) begin
         diff = goal - cur;
         return cur + ((diff > 10'(STEP)) ? 10'(STEP) : diff);
      end else begin
         diff = cur - goal;
         return cur - ((diff > 10'(STEP)) ? 10'(STEP) : diff);
      end
   endfunction

   function automatic logic [9:0] fall_sat(input logic [9:0] y);
      logic [10:0] sum;
      sum = {1'b0, y} + 11'(FALL_STEP);
      return (sum >= {1'b0, Y_SPAWN}) ? Y_SPAWN : sum[9:0];
   endfunction

   assign x_lo    = {2'b00, dx_q};
   assign x_hi    = x_lo + 12'(DUCK_W - 1);
   assign y_lo    = {2'b00, dy_q};
   assign y_hi    = y_lo + 12'(DUCK_H - 1);
   assign hit_now = bus.click && (bus.mouse_x >= x_lo) && (bus.mouse_x <= x_hi) &&
                    (bus.mouse_y >= y_lo) && (bus.mouse_y <= y_hi);
   assign at_goal = (dx_q == gx_q) && (dy_q == gy_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         dx_q    <= 10'd448;
         dy_q    <= Y_SPAWN;
         gx_q    <= 10'd448;
         gy_q    <= Y_SPAWN;
         cnt_q   <= '0;
         vis_q   <= 1'b0;
         dir_q   <= 1'b1;
         hit_q   <= 1'b0;
         esc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         gx_q    <= gx_d;
         gy_q    <= gy_d;
         cnt_q   <= cnt_d;
         vis_q   <= vis_d;
         dir_q   <= dir_d;
         hit_q   <= hit_d;
         esc_q   <= esc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      gx_d    = gx_q;
      gy_d    = gy_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      hit_d   = 1'b0;
      esc_d   = 1'b0;
      if (bus.state_in != PLAY) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:  state_d = SPAWN;
            SPAWN: begin
               dx_d    = clamp(bus.target_x, XC);
               dy_d    = Y_SPAWN;
               gx_d    = clamp(bus.target_x, XC);
               gy_d    = clamp(bus.target_y, Y_SPAWN);
               cnt_d   = '0;
               state_d = FLY;
            end
            FLY: begin
               // A hit is judged on the pre-move position and beats a timeout on the same tick.
               if (hit_now) begin
                  hit_d   = 1'b1;
                  state_d = FALL;
               end else if (bus.frame_tick) begin
                  cnt_d = cnt_q + 1'b1;
                  if (at_goal) begin
                     gx_d = clamp(bus.target_x, XC);
                     gy_d = clamp(bus.target_y, Y_SPAWN);
                  end else begin
                     dx_d = step_toward(dx_q, gx_q);
                     dy_d = step_toward(dy_q, gy_q);
                     if (gx_q > dx_q)      dir_d = 1'b1;
                     else if (gx_q < dx_q) dir_d = 1'b0;
                  end
                  if (cnt_d == CNT_W'(ESCAPE_FRAMES)) state_d = ESCAPE;
               end
            end
            FALL: begin
               if (bus.frame_tick) begin
                  dy_d = fall_sat(dy_q);
                  if (dy_d == Y_SPAWN) state_d = SPAWN;
               end
            end
            ESCAPE: begin
               if (bus.frame_tick) begin
                  if (dy_q >= 10'(STEP)) begin
                     dy_d = dy_q - 10'(STEP);
                  end else begin
                     dy_d    = '0;
                     esc_d   = 1'b1;
                     state_d = SPAWN;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
      vis_d = (state_d == FLY) || (state_d == FALL) || (state_d == ESCAPE);
   end

   assign bus.duck_x       = dx_q;
   assign bus.duck_y       = dy_q;
   assign bus.duck_visible = vis_q;
   assign bus.dir_right    = dir_q;
   assign bus.hit_pulse    = hit_q;
   assign bus.escape_pulse = esc_q;

endmodule

// File: tb/tb_duck_ctl.sv
// Directed bench for duck_ctl: spawn, flight, clamping, hit/fall, escape, priority and
// leaving play, all with hand-computed expected positions.
module tb_duck_ctl;
   logic clk = 1'b0;
   logic rst;
   int   passed = 0;
   int   total  = 0;

   duck_ctl_if bus ();

   duck_ctl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // One clock cycle with the given strobes; returns at the following negedge.
   task automatic cyc(input logic tick, input logic clk_in, input int mx, input int my);
      bus.frame_tick = tick;
      bus.click      = clk_in;
      bus.mouse_x    = 12'(mx);
      bus.mouse_y    = 12'(my);
      @(negedge clk);
      bus.frame_tick = 1'b0;
      bus.click      = 1'b0;
   endtask

   // n frames: an idle cycle then a tick cycle, so results are visible on return.
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(1'b0, 1'b0, 0, 0);
         cyc(1'b1, 1'b0, 0, 0);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.state_in = 2'b00;
      bus.target_x = 10'd0;
      bus.target_y = 10'd0;
      bus.frame_tick = 1'b0;
      bus.click = 1'b0;
      bus.mouse_x = '0;
      bus.mouse_y = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_x", bus.duck_x, 448);
      chk("rst_y", bus.duck_y, 640);
      chk("rst_vis", bus.duck_visible, 0);
      chk("rst_dir", bus.dir_right, 1);
      chk("rst_hit", bus.hit_pulse, 0);
      chk("rst_esc", bus.escape_pulse, 0);
      rst = 1'b0;

      // Spawn and straight vertical flight to (100,200)
      bus.state_in = 2'b01;
      bus.target_x = 10'd100;
      bus.target_y = 10'd200;
      cyc(1'b0, 1'b0, 0, 0);
      chk("spawn_vis", bus.duck_visible, 0);
      cyc(1'b0, 1'b0, 0, 0);
      chk("fly_x", bus.duck_x, 100);
      chk("fly_y", bus.duck_y, 640);
      chk("fly_vis", bus.duck_visible, 1);
      ticks(1);
      chk("fly_y1", bus.duck_y, 636);
      ticks(109);
      chk("fly_x110", bus.duck_x, 100);
      chk("fly_y110", bus.duck_y, 200);

      // At goal: reload without moving, then diagonal to (300,300)
      bus.target_x = 10'd300;
      bus.target_y = 10'd300;
      ticks(1);
      chk("reload_x", bus.duck_x, 100);
      chk("reload_y", bus.duck_y, 200);
      ticks(50);
      chk("diag_x", bus.duck_x, 300);
      chk("diag_y", bus.duck_y, 300);
      chk("diag_dir", bus.dir_right, 1);

      // Edge misses
      cyc(1'b0, 1'b1, 364, 300);
      chk("miss_right", bus.hit_pulse, 0);
      cyc(1'b0, 1'b1, 363, 299);
      chk("miss_top", bus.hit_pulse, 0);
      cyc(1'b0, 1'b1, 299, 330);
      chk("miss_left", bus.hit_pulse, 0);

      // Hit on bottom edge, fall to 640
      cyc(1'b0, 1'b1, 330, 363);
      chk("hit_pulse", bus.hit_pulse, 1);
      cyc(1'b0, 1'b0, 0, 0);
      chk("hit_once", bus.hit_pulse, 0);
      ticks(1);
      chk("fall_y1", bus.duck_y, 308);
      ticks(41);
      chk("fall_y42", bus.duck_y, 636);
      chk("fall_vis", bus.duck_visible, 1);
      bus.target_x = 10'd1000;
      bus.target_y = 10'd700;
      ticks(1);
      chk("fall_land_y", bus.duck_y, 640);
      chk("fall_respawn_vis", bus.duck_visible, 0);

      // Clamped spawn
      cyc(1'b0, 1'b0, 0, 0);
      chk("clamp_x", bus.duck_x, 896);
      chk("clamp_vis", bus.duck_visible, 1);
      ticks(1);
      chk("clamp_hold_x", bus.duck_x, 896);
      chk("clamp_hold_y", bus.duck_y, 640);

      // Leftward flight
      bus.target_x = 10'd880;
      bus.target_y = 10'd640;
      ticks(1);
      chk("left_reload", bus.duck_x, 896);
      ticks(1);
      chk("left_x", bus.duck_x, 892);
      chk("left_dir", bus.dir_right, 0);
      ticks(3);
      chk("left_arrive", bus.duck_x, 880);

      // Escape after 300 frames in FLY (6 so far)
      ticks(294);
      chk("esc_300_y", bus.duck_y, 640);
      ticks(1);
      chk("esc_up1", bus.duck_y, 636);
      ticks(159);
      chk("esc_top_y", bus.duck_y, 0);
      chk("esc_top_vis", bus.duck_visible, 1);
      chk("esc_top_pulse", bus.escape_pulse, 0);
      ticks(1);
      chk("esc_pulse", bus.escape_pulse, 1);
      chk("esc_vis", bus.duck_visible, 0);
      cyc(1'b0, 1'b0, 0, 0);
      chk("esc_once", bus.escape_pulse, 0);
      chk("esc_respawn_x", bus.duck_x, 880);
      chk("esc_respawn_y", bus.duck_y, 640);

      // Hit on the same tick as the timeout: hit wins
      ticks(299);
      cyc(1'b0, 1'b0, 0, 0);
      cyc(1'b1, 1'b1, 900, 660);
      chk("prio_hit", bus.hit_pulse, 1);
      chk("prio_esc", bus.escape_pulse, 0);
      ticks(1);
      chk("prio_fall_vis", bus.duck_visible, 0);
      chk("prio_fall_y", bus.duck_y, 640);
      chk("prio_no_esc", bus.escape_pulse, 0);
      cyc(1'b0, 1'b0, 0, 0);

      // Leave play mid-fall
      bus.target_y = 10'd600;
      ticks(11);
      chk("mid_y", bus.duck_y, 600);
      cyc(1'b0, 1'b1, 900, 620);
      chk("mid_hit", bus.hit_pulse, 1);
      ticks(1);
      chk("mid_fall_y", bus.duck_y, 608);
      bus.state_in = 2'b00;
      cyc(1'b0, 1'b0, 0, 0);
      chk("quit_vis", bus.duck_visible, 0);
      chk("quit_hit", bus.hit_pulse, 0);
      ticks(2);
      chk("quit_hold_y", bus.duck_y, 608);
      chk("quit_esc", bus.escape_pulse, 0);
      cyc(1'b0, 1'b1, 890, 610);
      chk("idle_click", bus.hit_pulse, 0);
      bus.target_x = 10'd40;
      bus.target_y = 10'd50;
      bus.state_in = 2'b01;
      cyc(1'b0, 1'b0, 0, 0);
      chk("replay_spawn_vis", bus.duck_visible, 0);
      cyc(1'b0, 1'b0, 0, 0);
      chk("replay_x", bus.duck_x, 40);
      chk("replay_y", bus.duck_y, 640);
      chk("replay_vis", bus.duck_visible, 1);
      ticks(1);
      chk("replay_move_y", bus.duck_y, 636);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
